// File: rtl/count_uart_reporter_pkg.sv
// Shared constants, FSM encoding and frame byte selection for count_uart_reporter.
// Optional CR/LF trailer is enabled by defining the CRLF_EN macro.
package count_uart_reporter_pkg;

   localparam logic [6:0] ASCII_ZERO = 7'h30;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   localparam logic [2:0] FRAME_LEN_BASE = 3'd2;
   localparam logic [2:0] FRAME_LEN_CRLF = 3'd4;

`ifdef CRLF_EN
   localparam logic [2:0] FRAME_LEN = FRAME_LEN_CRLF;
`else
   localparam logic [2:0] FRAME_LEN = FRAME_LEN_BASE;
`endif

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_NEXT  = 3'd4
   } tx_state_e;

   // Byte number idx of a frame built from a tens/ones snapshot.
   function automatic logic [7:0] frame_byte(
      input logic [2:0] idx,
      input logic [6:0] tens,
      input logic [6:0] ones
   );
      logic [7:0] b;
      b = {1'b0, ones};
      case (idx)
         3'd0: b = {1'b0, tens};
`ifdef CRLF_EN
         3'd2: b = ASCII_CR;
         3'd3: b = ASCII_LF;
`endif
         default: b = {1'b0, ones};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/count_uart_reporter_uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte per valid/ready handshake.
// Ports: clk, reset, valid, data[7:0] in; ready, tx, busy out.
module uart_tx_byte
   import count_uart_reporter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   // STOP covers all but the last stop-bit cycle; NEXT is that last
   // cycle, so the following start bit follows with no gap.
   localparam logic [TW-1:0] T_STOP = TW'(CLKS_PER_BIT - 2);

   tx_state_e     state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      ready     = 1'b0;
      tx        = 1'b1;
      busy      = (state_q != ST_IDLE);
      unique case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (valid) begin
               state_d   = ST_START;
               shift_d   = data;
               timer_d   = '0;
               bit_idx_d = '0;
            end
         end
         ST_START: begin
            tx = 1'b0;
            if (timer_q == T_LAST) begin
               timer_d = '0;
               state_d = ST_DATA;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_DATA: begin
            tx = shift_q[0];
            if (timer_q == T_LAST) begin
               timer_d   = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_STOP: begin
            if (timer_q == T_STOP) begin
               timer_d = '0;
               state_d = ST_NEXT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_NEXT: begin
            ready = 1'b1;
            if (valid) begin
               state_d   = ST_START;
               shift_d   = data;
               timer_d   = '0;
               bit_idx_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/count_uart_reporter.sv
// count_uart_reporter: sends the two-digit count over UART whenever it changes.
// Ports: clk, reset, ones_in[6:0], tens_in[6:0] in; tx, busy, frame_done out.
// Define CRLF_EN to append CR LF to every frame.
module count_uart_reporter
   import count_uart_reporter_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] ones_in,
   input  logic [6:0] tens_in,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   logic [6:0] shadow_tens_q, shadow_tens_d;
   logic [6:0] shadow_ones_q, shadow_ones_d;
   logic [6:0] snap_tens_q, snap_tens_d;
   logic [6:0] snap_ones_q, snap_ones_d;
   logic [2:0] byte_idx_q, byte_idx_d;
   logic       pending_q, pending_d;
   logic       frame_done_q, frame_done_d;

   logic       change;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_busy;

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk  (clk),
      .reset(reset),
      .valid(tx_valid),
      .data (tx_data),
      .ready(tx_ready),
      .tx   (tx),
      .busy (tx_busy)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_tens_q <= ASCII_ZERO;
         shadow_ones_q <= ASCII_ZERO;
         snap_tens_q   <= ASCII_ZERO;
         snap_ones_q   <= ASCII_ZERO;
         byte_idx_q    <= '0;
         pending_q     <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         shadow_tens_q <= shadow_tens_d;
         shadow_ones_q <= shadow_ones_d;
         snap_tens_q   <= snap_tens_d;
         snap_ones_q   <= snap_ones_d;
         byte_idx_q    <= byte_idx_d;
         pending_q     <= pending_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign change = ({tens_in, ones_in} != {shadow_tens_q, shadow_ones_q});

   always_comb begin
      shadow_tens_d = shadow_tens_q;
      shadow_ones_d = shadow_ones_q;
      snap_tens_d   = snap_tens_q;
      snap_ones_d   = snap_ones_q;
      byte_idx_d    = byte_idx_q;
      pending_d     = pending_q;
      frame_done_d  = 1'b0;
      tx_valid      = 1'b0;
      tx_data       = 8'h00;

      if (change) begin
         shadow_tens_d = tens_in;
         shadow_ones_d = ones_in;
      end

      if (!tx_busy) begin
         // Idle: first byte goes straight from the inputs so the start
         // bit appears the cycle after the change edge.
         if (change || pending_q) begin
            tx_valid    = 1'b1;
            tx_data     = {1'b0, tens_in};
            snap_tens_d = tens_in;
            snap_ones_d = ones_in;
            byte_idx_d  = 3'd1;
            pending_d   = 1'b0;
         end
      end else begin
         if (change) begin
            pending_d = 1'b1;
         end
         // Serializer is in its last stop-bit cycle.
         if (tx_ready) begin
            if (byte_idx_q < FRAME_LEN) begin
               tx_valid   = 1'b1;
               tx_data    = frame_byte(byte_idx_q, snap_tens_q, snap_ones_q);
               byte_idx_d = byte_idx_q + 3'd1;
            end else begin
               frame_done_d = 1'b1;
            end
         end
      end
   end

   assign busy       = tx_busy;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_count_uart_reporter.sv
// Self-checking bench for count_uart_reporter with CLKS_PER_BIT=4.
// Cycle-level reference model plus directed literal checks and random stimulus.
module tb_count_uart_reporter;

   localparam int C = 4;
`ifdef CRLF_EN
   localparam int FL = 4;
`else
   localparam int FL = 2;
`endif
   localparam int TOT = FL * 10 * C;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] ones_in = 7'h30;
   logic [6:0] tens_in = 7'h30;
   logic       tx;
   logic       busy;
   logic       frame_done;

   int total = 0;
   int bad = 0;

   count_uart_reporter #(.CLKS_PER_BIT(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .ones_in   (ones_in),
      .tens_in   (tens_in),
      .tx        (tx),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: frame timeline derived from cycles remaining.
   logic [6:0] m_sh_t = 7'h30;
   logic [6:0] m_sh_o = 7'h30;
   bit         m_pend = 0;
   int         m_rem = 0;
   bit         m_fd = 0;
   bit         m_valid = 0;
   logic [7:0] m_bytes [4];

   always @(posedge clk) begin
      bit chg;
      if (reset) begin
         m_rem = 0;
         m_pend = 0;
         m_sh_t = 7'h30;
         m_sh_o = 7'h30;
         m_fd = 0;
         m_valid = 1;
      end else begin
         chg = (tens_in != m_sh_t) || (ones_in != m_sh_o);
         m_fd = 0;
         if (m_rem > 0) begin
            if (chg) m_pend = 1;
            m_rem--;
            if (m_rem == 0) m_fd = 1;
         end else if (chg || m_pend) begin
            m_bytes[0] = {1'b0, tens_in};
            m_bytes[1] = {1'b0, ones_in};
            m_bytes[2] = 8'h0D;
            m_bytes[3] = 8'h0A;
            m_rem = TOT;
            m_pend = 0;
         end
         if (chg) begin
            m_sh_t = tens_in;
            m_sh_o = ones_in;
         end
      end
   end

   function automatic logic exp_tx();
      int pos, b, k;
      if (m_rem == 0) return 1'b1;
      pos = TOT - m_rem;
      b = pos / (10 * C);
      k = (pos % (10 * C)) / C;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return m_bytes[b][k-1];
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         chk("tx", tx, exp_tx());
         chk("busy", busy, m_rem > 0);
         chk("frame_done", frame_done, m_fd);
      end
   end

   // Activity counters and a line decoder for the literal checks.
   int busy_cycles = 0;
   int fd_pulses = 0;
   logic [7:0] dec_q[$];

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cycles++;
      if (frame_done === 1'b1) fd_pulses++;
   end

   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (m_valid && tx === 1'b0) begin
            repeat (C / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (C) @(negedge clk);
               b[i] = tx;
            end
            repeat (C) @(negedge clk);
            dec_q.push_back(b);
         end
      end
   end

   task automatic wait_fd(input string nm, input int lim);
      int n = 0;
      while (frame_done !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(nm, frame_done, 1'b1);
   endtask

   task automatic chk_dec(input string nm, input int base, input int idx,
                          input logic [7:0] exp);
      if (dec_q.size() > base + idx) chk(nm, dec_q[base + idx], exp);
      else chk({nm, "_missing"}, 32'(dec_q.size()), 32'(base + idx + 1));
   endtask

   initial begin
      int bb, bf, bd;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle with unchanged inputs.
      bb = busy_cycles; bf = fd_pulses;
      repeat (200) @(negedge clk);
      #1;
      chk("t1_busy_cycles", busy_cycles - bb, 0);
      chk("t1_fd_pulses", fd_pulses - bf, 0);
      chk("t1_tx_idle", tx, 1'b1);

      // Single ones change.
      @(negedge clk);
      bb = busy_cycles; bf = fd_pulses; bd = dec_q.size();
      ones_in = 7'h31;
      wait_fd("t2_fd_timeout", 400);
      repeat (2) @(negedge clk);
      #1;
`ifdef CRLF_EN
      chk("t2_busy_cycles", busy_cycles - bb, 160);
`else
      chk("t2_busy_cycles", busy_cycles - bb, 80);
`endif
      chk("t2_fd_pulses", fd_pulses - bf, 1);
      chk_dec("t2_byte0", bd, 0, 8'h30);
      chk_dec("t2_byte1", bd, 1, 8'h31);
`ifdef CRLF_EN
      chk_dec("t2_byte2", bd, 2, 8'h0D);
      chk_dec("t2_byte3", bd, 3, 8'h0A);
`endif

      // Both digits change in one edge; later change must not alter it.
      ones_in = 7'h39;
      wait_fd("t3a_fd_timeout", 400);
      repeat (3) @(negedge clk);
      bd = dec_q.size();
      tens_in = 7'h31; ones_in = 7'h30;
      repeat (10) @(negedge clk);
      tens_in = 7'h35; ones_in = 7'h36;
      wait_fd("t3b_fd_timeout", 400);
      #1;
      chk_dec("t3_byte0", bd, 0, 8'h31);
      chk_dec("t3_byte1", bd, 1, 8'h30);
      @(negedge clk);
      wait_fd("t3c_fd_timeout", 400);
      repeat (3) @(negedge clk);

      // Three changes during one frame -> one follow-up frame.
      bf = fd_pulses;
      ones_in = 7'h37;
      repeat (10) @(negedge clk);
      ones_in = 7'h32;
      repeat (10) @(negedge clk);
      ones_in = 7'h33;
      repeat (10) @(negedge clk);
      ones_in = 7'h34;
      wait_fd("t4a_fd_timeout", 400);
      @(negedge clk);
      chk("t4_start_tx", tx, 1'b0);
      chk("t4_start_busy", busy, 1'b1);
      bd = dec_q.size();
      wait_fd("t4b_fd_timeout", 400);
      repeat (3) @(negedge clk);
      #1;
      chk("t4_fd_pulses", fd_pulses - bf, 2);
      chk_dec("t4_byte0", bd, 0, 8'h35);
      chk_dec("t4_byte1", bd, 1, 8'h34);
      repeat (100) @(negedge clk);
      chk("t4_no_extra", fd_pulses - bf, 2);

      // Reset during data of byte 2.
      ones_in = 7'h38;
      repeat (10 * C + C + 3 * C) @(negedge clk);
      reset = 1'b1;
      tens_in = 7'h30; ones_in = 7'h30;
      @(negedge clk);
      chk("t5_tx_after_reset", tx, 1'b1);
      chk("t5_busy_after_reset", busy, 1'b0);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      bd = dec_q.size();
      ones_in = 7'h32;
      wait_fd("t5_fd_timeout", 400);
      repeat (2) @(negedge clk);
      #1;
      chk_dec("t5_byte0", bd, 0, 8'h30);
      chk_dec("t5_byte1", bd, 1, 8'h32);

      // Random changes and resets against the model.
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(1, 120)) @(negedge clk);
         if ($urandom_range(0, 9) == 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end else if ($urandom_range(0, 1) == 0) begin
            tens_in = 7'(7'h30 + $urandom_range(0, 9));
         end else begin
            ones_in = 7'(7'h30 + $urandom_range(0, 9));
         end
      end
      repeat (2 * TOT + 20) @(negedge clk);
      chk("end_idle_busy", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
